// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding unit: mux select encodings,
// default register-address width and the shadow pipeline stage record.
package hazard_forward_unit_pkg;

  localparam int AW_DEFAULT = 5;

  localparam logic [1:0] SEL_REGFILE = 2'd0;
  localparam logic [1:0] SEL_EXMEM   = 2'd1;
  localparam logic [1:0] SEL_MEMWB   = 2'd2;

  // Destination-register information tracked for one pipeline stage.
  typedef struct packed {
    logic                  valid;
    logic [AW_DEFAULT-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_t;

  // Youngest producer wins: an EX-stage match beats a MEM-stage match.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    logic [1:0] sel;
    if (ex_hit) begin
      sel = SEL_EXMEM;
    end else if (mem_hit) begin
      sel = SEL_MEMWB;
    end else begin
      sel = SEL_REGFILE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// "Stage writes src" comparator: one instance per tracked stage per source
// operand. Register 0 is hard-wired, so it never produces a match.
module hazard_match
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          use_i,
  input  logic [AW-1:0] src_i,
  input  logic          valid_i,
  input  logic          regwrite_i,
  input  logic [AW-1:0] rd_i,
  output logic          hit_o
);

  assign hit_o = use_i & valid_i & regwrite_i & (rd_i == src_i) & (src_i != {AW{1'b0}});

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// Build option FORWARD_EN: when defined, EX/MEM and MEM/WB results are
// forwarded and only load-use stalls; when undefined, selects stay at the
// register file and any EX/MEM producer of a used source stalls ID.
// The WB-stage producer needs no state here: the write-first register file
// already returns its result to the instruction in ID.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  output logic [1:0]    sel_a,
  output logic [1:0]    sel_b,
  output logic          stall,
  output logic          ex_bubble
);

  localparam int RW = AW_DEFAULT;

  logic [RW-1:0] rs_w;
  logic [RW-1:0] rt_w;
  logic [RW-1:0] rd_w;

  stage_t        ex_q;
  stage_t        ex_d;
  logic          mem_valid_q;
  logic [RW-1:0] mem_rd_q;
  logic          mem_regwrite_q;

  logic ex_rs_hit;
  logic ex_rt_hit;
  logic mem_rs_hit;
  logic mem_rt_hit;
  logic ex_load_hit;
  logic hazard;
  logic stall_raw;
  logic bubble_raw;
  logic issue;

  assign rs_w = RW'(id_rs);
  assign rt_w = RW'(id_rt);
  assign rd_w = RW'(id_rd);

  hazard_match #(.AW(RW)) u_ex_rs (
    .use_i      (id_use_rs),
    .src_i      (rs_w),
    .valid_i    (ex_q.valid),
    .regwrite_i (ex_q.regwrite),
    .rd_i       (ex_q.rd),
    .hit_o      (ex_rs_hit)
  );

  hazard_match #(.AW(RW)) u_ex_rt (
    .use_i      (id_use_rt),
    .src_i      (rt_w),
    .valid_i    (ex_q.valid),
    .regwrite_i (ex_q.regwrite),
    .rd_i       (ex_q.rd),
    .hit_o      (ex_rt_hit)
  );

  hazard_match #(.AW(RW)) u_mem_rs (
    .use_i      (id_use_rs),
    .src_i      (rs_w),
    .valid_i    (mem_valid_q),
    .regwrite_i (mem_regwrite_q),
    .rd_i       (mem_rd_q),
    .hit_o      (mem_rs_hit)
  );

  hazard_match #(.AW(RW)) u_mem_rt (
    .use_i      (id_use_rt),
    .src_i      (rt_w),
    .valid_i    (mem_valid_q),
    .regwrite_i (mem_regwrite_q),
    .rd_i       (mem_rd_q),
    .hit_o      (mem_rt_hit)
  );

  // A load in EX cannot forward in time: its data only exists after MEM.
  assign ex_load_hit = ex_q.memread & (ex_rs_hit | ex_rt_hit);

`ifdef FORWARD_EN
  assign hazard = id_valid & ex_load_hit;
`else
  // Without forwarding every EX/MEM producer blocks; loads are a subset.
  assign hazard = id_valid & (ex_load_hit | ex_rs_hit | ex_rt_hit | mem_rs_hit | mem_rt_hit);
`endif

  // A flushed instruction is discarded, so it never needs to wait.
  assign stall_raw  = hazard & ~flush;
  assign bubble_raw = hazard | flush;
  assign issue      = id_valid & ~bubble_raw;

  // Reset forces the pipeline controls low even while ID inputs show a hazard.
  assign stall     = rst_n & stall_raw;
  assign ex_bubble = rst_n & bubble_raw;

  // Next EX shadow record: the ID instruction if it issues, otherwise a bubble.
  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = rd_w;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end else begin
      ex_d = '0;
    end
  end

  // Shadow pipeline advance: MEM takes EX, EX takes the issued record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= '0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= {RW{1'b0}};
      mem_regwrite_q <= 1'b0;
    end else begin
      ex_q           <= ex_d;
      mem_valid_q    <= ex_q.valid;
      mem_rd_q       <= ex_q.rd;
      mem_regwrite_q <= ex_q.regwrite;
    end
  end

`ifdef FORWARD_EN
  logic [1:0] sel_a_q;
  logic [1:0] sel_a_d;
  logic [1:0] sel_b_q;
  logic [1:0] sel_b_d;

  // Forwarding source for the ID instruction, decided one cycle before it reaches EX.
  always_comb begin
    sel_a_d = SEL_REGFILE;
    sel_b_d = SEL_REGFILE;
    if (issue) begin
      sel_a_d = fwd_sel(ex_rs_hit, mem_rs_hit);
      sel_b_d = fwd_sel(ex_rt_hit, mem_rt_hit);
    end else begin
      sel_a_d = SEL_REGFILE;
      sel_b_d = SEL_REGFILE;
    end
  end

  // Present the selects aligned with the instruction now in EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_a_q <= SEL_REGFILE;
      sel_b_q <= SEL_REGFILE;
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign sel_a = sel_a_q;
  assign sel_b = sel_b_q;
`else
  assign sel_a = SEL_REGFILE;
  assign sel_b = SEL_REGFILE;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed, table-driven bench for hazard_forward_unit. Each table row is one
// ID-stage cycle: inputs driven after the rising edge, outputs compared 1 ns
// later. Expected sel_a/sel_b are those for the instruction then in EX.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       flush;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       stall;
  logic       ex_bubble;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       st;
    logic       bb;
    logic [1:0] sa;
    logic [1:0] sb;
  } vec_t;

  vec_t tbl[$];
  vec_t hand[$];

  hazard_forward_unit #(.AW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .stall       (stall),
    .ex_bubble   (ex_bubble)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int v, input int rs, input int rt, input int urs,
                              input int urt, input int rd, input int rw, input int mr,
                              input int fl, input int st, input int bb, input int sa,
                              input int sb);
    vec_t r;
    r.v   = v[0];
    r.rs  = rs[4:0];
    r.rt  = rt[4:0];
    r.urs = urs[0];
    r.urt = urt[0];
    r.rd  = rd[4:0];
    r.rw  = rw[0];
    r.mr  = mr[0];
    r.fl  = fl[0];
    r.st  = st[0];
    r.bb  = bb[0];
    r.sa  = sa[1:0];
    r.sb  = sb[1:0];
    return r;
  endfunction

  // Empty ID slot with the expected outputs for that cycle.
  function automatic vec_t nop(input int st, input int bb, input int sa, input int sb);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, st, bb, sa, sb);
  endfunction

  task automatic chk(input string name, input int idx, input logic [1:0] act,
                     input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    id_valid    = r.v;
    id_rs       = r.rs;
    id_rt       = r.rt;
    id_use_rs   = r.urs;
    id_use_rt   = r.urt;
    id_rd       = r.rd;
    id_regwrite = r.rw;
    id_memread  = r.mr;
    flush       = r.fl;
  endtask

  task automatic check_out(input string tag, input int idx, input vec_t r);
    chk({tag, "_stall"}, idx, {1'b0, stall}, {1'b0, r.st});
    chk({tag, "_bubble"}, idx, {1'b0, ex_bubble}, {1'b0, r.bb});
    chk({tag, "_sel_a"}, idx, sel_a, r.sa);
    chk({tag, "_sel_b"}, idx, sel_b, r.sb);
  endtask

  task automatic step(input string tag, input int idx, input vec_t r);
    @(posedge clk);
    #1;
    drive(r);
    #1;
    check_out(tag, idx, r);
  endtask

  initial begin
    // fields: v rs rt urs urt rd rw mr fl | stall bubble sel_a sel_b
`ifdef FORWARD_EN
    tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3<-r1,r2
    tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0));  // sub r4<-r3,r5
    tbl.push_back(nop(0, 0, 1, 0));                            // sub in EX: A from EX/MEM
    tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3
    tbl.push_back(nop(0, 0, 0, 0));
    tbl.push_back(mk(1, 7, 3, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0));  // or r6<-r7,r3
    tbl.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 2));  // lw r8; or in EX: B from MEM/WB
    tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 1, 0, 0));  // add r9<-r8,r8: load-use
    tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));  // held, load now in MEM
    tbl.push_back(nop(0, 0, 2, 2));                            // add in EX: both from MEM/WB
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // write r0
    tbl.push_back(mk(1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));  // read r0,r0
    tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3; r0 reader sel 0
    tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3 again
    tbl.push_back(mk(1, 3, 3, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0));  // EX and MEM both write r3
    tbl.push_back(nop(0, 0, 1, 1));                            // youngest producer wins
    tbl.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // lw r8
    tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 1, 0, 1, 0, 0));  // dependent + flush
    tbl.push_back(mk(1, 8, 9, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0)); // r9 never written
    tbl.push_back(nop(0, 0, 2, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // lw r8
    tbl.push_back(mk(1, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // fields match but unused
    tbl.push_back(nop(0, 0, 0, 0));

    hand.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0)); // add r3
    hand.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0)); // sub r4<-r3
    hand.push_back(mk(1, 4, 0, 1, 0, 8, 1, 1, 0, 0, 0, 1, 0)); // lw r8<-r4
    hand.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 1, 1, 0)); // load-use stall
`else
    tbl.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));  // add r3<-r1,r2
    tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 1, 0, 0));  // sub r4<-r3: EX producer
    tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 1, 0, 0));  // MEM producer
    tbl.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0));  // released
    tbl.push_back(nop(0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // lw r8
    tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 1, 0, 0));  // add r9<-r8,r8
    tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(nop(0, 0, 0, 0));
    tbl.push_back(mk(1, 7, 9, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0));  // or r6<-r7,r9: MEM-only
    tbl.push_back(mk(1, 7, 9, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0));  // one cycle only
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // write r0
    tbl.push_back(mk(1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0));  // read r0: no stall
    tbl.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // lw r8
    tbl.push_back(mk(1, 8, 8, 1, 1, 9, 1, 0, 1, 0, 1, 0, 0));  // dependent + flush
    tbl.push_back(mk(1, 9, 9, 1, 1, 10, 0, 0, 0, 0, 0, 0, 0)); // flushed r9 absent
    tbl.push_back(mk(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 0, 0));  // lw r8
    tbl.push_back(mk(1, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // fields match but unused
    tbl.push_back(mk(1, 8, 0, 1, 0, 11, 1, 0, 0, 1, 1, 0, 0)); // r8 producer in MEM
    tbl.push_back(mk(1, 8, 0, 1, 0, 11, 1, 0, 0, 0, 0, 0, 0));

    hand.push_back(mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0)); // add r3
    hand.push_back(mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 1, 1, 0, 0)); // dependent stall
`endif

    // Reset state
    rst_n = 1'b0;
    drive(nop(0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, nop(0, 0, 0, 0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step("tbl", i, tbl[i]);
    end

    // Fresh pipeline for the reset-during-stall sequence
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(nop(0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (hand[i]) begin
      step("seq", i, hand[i]);
    end

    // Asynchronous reset while the stall is showing; ID inputs stay put
    #1;
    rst_n = 1'b0;
    #1;
    check_out("rst_mid_stall", 0, nop(0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_out("post_reset", 0, nop(0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
